// File: rtl/ahb_txn_scheduler.sv
// ahb_txn_scheduler
//   Arbitrated AHB master front-end. NREQ requesters post single read/write
//   commands over valid/ready; a round-robin arbiter grants one per IDLE
//   cycle. Each grant runs as one NONSEQ SINGLE transfer (address phase,
//   then a data phase that waits on hreadyout). A one-cycle response pulse
//   returns read data and the error flag to the granted requester.
//
//   Optional feature macro: AHB_SCHED_TIMEOUT_EN
//     defined   : the data phase aborts with an error after TMO_CYC
//                 hreadyout-low cycles
//     undefined : the data phase waits indefinitely
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready      per-requester command handshake (ready one-hot, comb)
//     req_write/size/addr/wdata per-requester command fields (packed, index 0 lsb)
//     rsp_valid                per-requester completion pulse
//     rsp_rdata, rsp_err       shared response data / error, valid with rsp_valid
//     haddr..hwdata, hreadyin  AHB master outputs toward the bridge
//     hrdata, hreadyout, hresp AHB responses from the bridge
//
//   state | meaning
//   IDLE  | arbitrate; accept one command
//   ADDR  | address phase, htrans=NONSEQ (one cycle)
//   DATA  | data phase, wait for hreadyout
//   RESP  | rsp_valid pulse to the granted requester (one cycle)

module ahb_txn_scheduler #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NREQ    = 2,
    parameter int TMO_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [3*NREQ-1:0]      req_size,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      haddr,
    output logic [1:0]             htrans,
    output logic                   hwrite,
    output logic [2:0]             hsize,
    output logic [2:0]             hburst,
    output logic                   hreadyin,
    output logic [DATA_W-1:0]      hwdata,
    input  logic [DATA_W-1:0]      hrdata,
    input  logic                   hreadyout,
    input  logic [1:0]             hresp
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    if (NREQ < 1 || TMO_CYC < 1) begin : g_bad_param
        $error("ahb_txn_scheduler: NREQ and TMO_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t              state;
    logic [GW-1:0]       ptr;
    logic [GW-1:0]       gnt_q;
    logic                cmd_write;
    logic [DATA_W-1:0]   cmd_wdata;

    logic                gnt_found;
    logic [GW-1:0]       gnt_idx;
    logic [GW-1:0]       ptr_next;
    logic                sel_write;
    logic [2:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

`ifdef AHB_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0]    tmo_cnt;
`endif

    // Round-robin: first valid index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = GW'(idx);
                sel_write = req_write[idx];
                sel_size  = req_size[idx*3 +: 3];
                sel_addr  = req_addr[idx*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (gnt_idx == GW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Gated by rst so no handshake is seen on an edge that the reset overrides.
    assign req_ready = (state == S_IDLE && gnt_found && !rst)
                     ? (NREQ'(1) << gnt_idx) : '0;

    assign hburst = 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gnt_q     <= '0;
            cmd_write <= 1'b0;
            cmd_wdata <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            haddr     <= '0;
            htrans    <= 2'b00;
            hwrite    <= 1'b0;
            hsize     <= '0;
            hreadyin  <= 1'b0;
            hwdata    <= '0;
`ifdef AHB_SCHED_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            hreadyin <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        gnt_q     <= gnt_idx;
                        ptr       <= ptr_next;
                        cmd_write <= sel_write;
                        cmd_wdata <= sel_wdata;
                        if (sel_size > MAX_SIZE) begin
                            // Oversized beat: reject without touching the bus.
                            state     <= S_RESP;
                            rsp_valid <= NREQ'(1) << gnt_idx;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state  <= S_ADDR;
                            htrans <= 2'b10;
                            haddr  <= sel_addr;
                            hwrite <= sel_write;
                            hsize  <= sel_size;
                        end
                    end
                end
                S_ADDR: begin
                    state  <= S_DATA;
                    htrans <= 2'b00;
                    hwdata <= cmd_write ? cmd_wdata : '0;
`ifdef AHB_SCHED_TIMEOUT_EN
                    tmo_cnt <= TMO_W'(TMO_CYC - 1);
`endif
                end
                S_DATA: begin
                    if (hreadyout) begin
                        state     <= S_RESP;
                        rsp_valid <= NREQ'(1) << gnt_q;
                        rsp_err   <= |hresp;
                        rsp_rdata <= (!cmd_write && hresp == 2'b00) ? hrdata : '0;
                        hwdata    <= '0;
                    end
`ifdef AHB_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        state     <= S_RESP;
                        rsp_valid <= NREQ'(1) << gnt_q;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        hwdata    <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_txn_scheduler.sv
module tb_ahb_txn_scheduler;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NREQ   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_write;
    logic [3*NREQ-1:0]      req_size;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [ADDR_W-1:0]      haddr;
    logic [1:0]             htrans;
    logic                   hwrite;
    logic [2:0]             hsize;
    logic [2:0]             hburst;
    logic                   hreadyin;
    logic [DATA_W-1:0]      hwdata;
    logic [DATA_W-1:0]      hrdata;
    logic                   hreadyout;
    logic [1:0]             hresp;

    int checks = 0;
    int errors = 0;

    ahb_txn_scheduler #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NREQ   (NREQ),
        .TMO_CYC(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size (req_size),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hreadyin (hreadyin),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hreadyout(hreadyout),
        .hresp    (hresp)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        hrdata = '0; hreadyout = 1'b0; hresp = 2'b00;
        tick(); tick();
        checks++;
        if (htrans !== 2'b00 || hreadyin !== 1'b0 || rsp_valid !== 2'b00 || haddr !== 32'h0
            || hwrite !== 1'b0 || hsize !== 3'b000 || hburst !== 3'b000 || hwdata !== 32'h0
            || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: htrans=%b hreadyin=%b rsp_valid=%b haddr=%h hwdata=%h rsp_err=%b, required all zero",
                     htrans, hreadyin, rsp_valid, haddr, hwdata, rsp_err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (hreadyin !== 1'b1) begin
            errors++;
            $display("FAIL hreadyin_after_reset: got %b required 1", hreadyin);
        end
    endtask

    task automatic test_single_read();
        req_valid = 2'b01; req_write[0] = 1'b0; req_size[2:0] = 3'd0;
        req_addr[31:0] = 32'h8000_00A2;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rd_ready: got %b required 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'h8000_00A2 || hwrite !== 1'b0 || hsize !== 3'd0) begin
            errors++;
            $display("FAIL rd_addr_phase: htrans=%b haddr=%h hwrite=%b hsize=%0d required 10 800000a2 0 0",
                     htrans, haddr, hwrite, hsize);
        end
        tick();
        checks++;
        if (htrans !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rd_data_phase: htrans=%b req_ready=%b required 00 00", htrans, req_ready);
        end
        tick();
        hreadyout = 1'b1; hrdata = 32'h0000_FFFF;
        tick();
        hreadyout = 1'b0; hrdata = 32'h0;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0000_FFFF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: rsp_valid=%b rdata=%h err=%b required 01 0000ffff 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL rd_resp_pulse: rsp_valid=%b required 00", rsp_valid);
        end
    endtask

    task automatic test_single_write();
        req_valid = 2'b10; req_write[1] = 1'b1; req_size[5:3] = 3'd0;
        req_addr[63:32] = 32'h8000_0001; req_wdata[63:32] = 32'hA300_1111;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL wr_ready: got %b required 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'h8000_0001 || hwrite !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr_phase: htrans=%b haddr=%h hwrite=%b required 10 80000001 1", htrans, haddr, hwrite);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (hwdata !== 32'hA300_1111 || hwrite !== 1'b1 || htrans !== 2'b00) begin
                errors++;
                $display("FAIL wr_data_phase%0d: hwdata=%h hwrite=%b htrans=%b required a3001111 1 00",
                         i, hwdata, hwrite, htrans);
            end
        end
        hreadyout = 1'b1;
        tick();
        hreadyout = 1'b0;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_resp: rsp_valid=%b err=%b rdata=%h required 10 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask

    // Both requesters hold valid continuously; grants must alternate.
    task automatic test_back_to_back();
        logic [1:0] exp_g;
        int n;
        req_valid = 2'b11; req_write = 2'b00; req_size = '0;
        req_addr = {32'h8000_0200, 32'h8000_0100};
        hreadyout = 1'b1; hrdata = 32'h5A5A_0001;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (req_ready === 2'b00 && n < 8) begin tick(); n++; end
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL rr_grant%0d: req_ready=%b required %b", i, req_ready, exp_g);
            end
            tick();
            n = 0;
            while (rsp_valid === 2'b00 && n < 8) begin tick(); n++; end
            checks++;
            if (rsp_valid !== exp_g || rsp_rdata !== 32'h5A5A_0001) begin
                errors++;
                $display("FAIL rr_resp%0d: rsp_valid=%b rdata=%h required %b 5a5a0001", i, rsp_valid, rsp_rdata, exp_g);
            end
        end
        req_valid = 2'b00; hreadyout = 1'b0; hrdata = 32'h0;
        tick();
    endtask

    task automatic test_illegal_size();
        req_valid = 2'b01; req_write[0] = 1'b0; req_size[2:0] = 3'b011;
        req_addr[31:0] = 32'h8000_0300;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL ill_ready: got %b required 01", req_ready);
        end
        tick();
        req_valid = 2'b00; req_size[2:0] = 3'b000;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || htrans !== 2'b00 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL ill_resp: rsp_valid=%b err=%b htrans=%b rdata=%h required 01 1 00 0",
                     rsp_valid, rsp_err, htrans, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00 || htrans !== 2'b00) begin
            errors++; $display("FAIL ill_after: rsp_valid=%b htrans=%b required 00 00", rsp_valid, htrans);
        end
    endtask

    task automatic test_error_resp();
        req_valid = 2'b01; req_write[0] = 1'b0; req_size[2:0] = 3'd2;
        req_addr[31:0] = 32'h8000_0400;
        hreadyout = 1'b1; hresp = 2'b01; hrdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL err_ready: got %b required 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (hsize !== 3'd2 || htrans !== 2'b10) begin
            errors++; $display("FAIL err_addr_phase: hsize=%0d htrans=%b required 2 10", hsize, htrans);
        end
        tick(); tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_resp: rsp_valid=%b err=%b rdata=%h required 01 1 0", rsp_valid, rsp_err, rsp_rdata);
        end
        hreadyout = 1'b0; hresp = 2'b00; hrdata = 32'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b10; req_write[1] = 1'b1; req_size[5:3] = 3'd2;
        req_addr[63:32] = 32'h8000_0040; req_wdata[63:32] = 32'h1234_5678;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL rst_mid_ready: got %b required 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (hwdata !== 32'h1234_5678 || htrans !== 2'b00) begin
            errors++; $display("FAIL rst_mid_data: hwdata=%h htrans=%b required 12345678 00", hwdata, htrans);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hreadyout = 1'b1;
        checks++;
        if (htrans !== 2'b00 || hreadyin !== 1'b0 || rsp_valid !== 2'b00 || haddr !== 32'h0 || hwdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_values: htrans=%b hreadyin=%b rsp_valid=%b haddr=%h hwdata=%h required 00 0 00 0 0",
                     htrans, hreadyin, rsp_valid, haddr, hwdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 2'b00 || hreadyin !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_dropped%0d: rsp_valid=%b hreadyin=%b required 00 1", i, rsp_valid, hreadyin);
            end
        end
        hreadyout = 1'b0;
        // Pointer back at 0: with both valid, requester 0 wins.
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_mid_ptr: req_ready=%b required 01", req_ready);
        end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_timeout();
        req_valid = 2'b01; req_write[0] = 1'b0; req_size[2:0] = 3'd0;
        req_addr[31:0] = 32'h8000_0500;
        hreadyout = 1'b0;
        tick();
        req_valid = 2'b00;
        tick();
`ifdef AHB_SCHED_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 2'b00) begin
                errors++; $display("FAIL tmo_early%0d: rsp_valid=%b required 00", i, rsp_valid);
            end
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || htrans !== 2'b00) begin
            errors++;
            $display("FAIL tmo_resp: rsp_valid=%b err=%b rdata=%h htrans=%b required 01 1 0 00",
                     rsp_valid, rsp_err, rsp_rdata, htrans);
        end
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 2'b00 || htrans !== 2'b00) begin
                errors++;
                $display("FAIL no_tmo_cycle%0d: rsp_valid=%b htrans=%b required 00 00", i, rsp_valid, htrans);
            end
        end
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL no_tmo_still_data: req_ready=%b required 00", req_ready);
        end
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_illegal_size();
        test_error_resp();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
